// File: rtl/alu_issue_queue.sv
// alu_issue_queue: command FIFO feeding an issue register that drives an
// external combinational ALU, whose result is captured in an output register.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid/in_ready     command handshake (in_a, in_b, in_sel)
//   alu_a/alu_b/alu_sel   registered operands/opcode to the downstream ALU
//   alu_y                 combinational ALU result (17 bits, carry included)
//   out_valid/out_ready   result handshake (out_y, out_sel)
//   fifo_count            FIFO occupancy, 0..DEPTH
//   op_count              completed output transfers, wraps at 16 bits
module alu_issue_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_a,
  input  logic [15:0]            in_b,
  input  logic [2:0]             in_sel,
  output logic [15:0]            alu_a,
  output logic [15:0]            alu_b,
  output logic [2:0]             alu_sel,
  input  logic [16:0]            alu_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16:0]            out_y,
  output logic [2:0]             out_sel,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            op_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  sel;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          iss_valid;
  logic          push;
  logic          pop;
  logic          res_load;
  logic          iss_free;
  logic          xfer;

  assign in_ready = (fifo_count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign res_load = iss_valid && (!out_valid || out_ready);
  assign iss_free = !iss_valid || res_load;
  // Pop looks at occupancy before this cycle's push, so a command never
  // bypasses the FIFO straight into the issue register.
  assign pop      = (fifo_count != '0) && iss_free;
  assign xfer     = out_valid && out_ready;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: in_a, b: in_b, sel: in_sel};
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
    end else if (pop) begin
      iss_valid <= 1'b1;
      alu_a     <= head.a;
      alu_b     <= head.b;
      alu_sel   <= head.sel;
    end else if (iss_free) begin
      iss_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_sel   <= '0;
    end else if (res_load) begin
      out_valid <= 1'b1;
      out_y     <= alu_y;
      out_sel   <= alu_sel;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (xfer) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue. The bench models the downstream
// ALU itself and keeps a queue-based reference of accepted commands.
module tb_alu_issue_queue;

  localparam int unsigned DEPTH = 4;

  logic                   clk;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [15:0]            in_a;
  logic [15:0]            in_b;
  logic [2:0]             in_sel;
  logic [15:0]            alu_a;
  logic [15:0]            alu_b;
  logic [2:0]             alu_sel;
  logic [16:0]            alu_y;
  logic                   out_valid;
  logic                   out_ready;
  logic [16:0]            out_y;
  logic [2:0]             out_sel;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0]            op_count;

  int n_checks;
  int n_pass;

  logic [19:0] exp_q[$];
  logic [19:0] got_q[$];
  logic [34:0] acc_q[$];
  logic [15:0] op_model;

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_y      (alu_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_sel    (out_sel),
    .fifo_count (fifo_count),
    .op_count   (op_count)
  );

  function automatic logic [16:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] s);
    logic [31:0] p;
    case (s)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: begin p = a * b; return p[16:0]; end
      3'd2: return {1'b0, a} - {1'b0, b};
      3'd3: return {1'b0, a & b};
      3'd4: return {1'b0, a | b};
      3'd5: return {1'b0, a ^ b};
      3'd6: return {1'b0, a} << b[3:0];
      default: return {1'b0, a >> b[3:0]};
    endcase
  endfunction

  assign alu_y = alu_ref(alu_a, alu_b, alu_sel);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // One clock: record handshakes seen before the edge, then step to 1 time unit after it.
  task automatic cycle();
    logic push_now;
    logic xfer_now;
    push_now = (in_valid === 1'b1) && (in_ready === 1'b1) && (rst !== 1'b1);
    xfer_now = (out_valid === 1'b1) && (out_ready === 1'b1) && (rst !== 1'b1);
    if (push_now) begin
      exp_q.push_back({alu_ref(in_a, in_b, in_sel), in_sel});
      acc_q.push_back({in_a, in_b, in_sel});
    end
    if (xfer_now) begin
      got_q.push_back({out_y, out_sel});
      op_model = op_model + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int queue_mismatches();
    int m;
    m = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    acc_q.delete();
  endtask

  task automatic rand_cmd();
    in_a   = 16'($urandom);
    in_b   = 16'($urandom);
    in_sel = 3'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sel = '0;
    cycle(); cycle();
    rst = 1'b0;
    op_model = '0;
    clear_model();
    n_checks++; if (fifo_count !== 0) $display("FAIL reset_fifo_count: got %0d, expected 0", fifo_count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, expected 0", out_valid); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_sel} !== 35'h0) $display("FAIL reset_alu_regs: got %h, expected 0", {alu_a, alu_b, alu_sel}); else n_pass++;
    n_checks++; if ({out_y, out_sel} !== 20'h0) $display("FAIL reset_out_regs: got %h, expected 0", {out_y, out_sel}); else n_pass++;
    n_checks++; if (op_count !== 16'h0) $display("FAIL reset_op_count: got %h, expected 0", op_count); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_single_op();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'h0003; in_b = 16'h0005; in_sel = 3'b001;
    cycle();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_lat_k: got out_valid %b, expected 0", out_valid); else n_pass++;
    cycle();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_lat_k1: got out_valid %b, expected 0", out_valid); else n_pass++;
    cycle();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_lat_k2: got out_valid %b, expected 1", out_valid); else n_pass++;
    n_checks++; if (out_y !== 17'd15) $display("FAIL single_out_y: got %h, expected 0000f", out_y); else n_pass++;
    n_checks++; if (out_sel !== 3'b001) $display("FAIL single_out_sel: got %b, expected 001", out_sel); else n_pass++;
    cycle();
    n_checks++; if (op_count !== 16'd1) $display("FAIL single_op_count: got %0d, expected 1", op_count); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_out_clear: got %b, expected 0", out_valid); else n_pass++;
    // add carry must reach bit 16
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_sel = 3'b000;
    cycle();
    in_valid = 1'b0;
    cycle(); cycle();
    n_checks++; if (out_y !== 17'h10000) $display("FAIL carry_out_y: got %h, expected 10000", out_y); else n_pass++;
    cycle();
    n_checks++; if (got_q.size() !== 2 || queue_mismatches() !== 0)
      $display("FAIL single_scoreboard: got %0d results with %0d mismatches, expected 2 with 0", got_q.size(), queue_mismatches());
    else n_pass++;
    clear_model();
  endtask

  task automatic test_fill_drain();
    logic [19:0] s_out;
    logic [34:0] s_iss;
    logic [$clog2(DEPTH):0] s_cnt;
    int gaps;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int unsigned i = 0; i < DEPTH + 3; i++) begin
      rand_cmd();
      cycle();
    end
    in_valid = 1'b0;
    n_checks++; if (exp_q.size() !== DEPTH + 2) $display("FAIL fill_accepted: got %0d, expected %0d", exp_q.size(), DEPTH + 2); else n_pass++;
    n_checks++; if (fifo_count !== DEPTH) $display("FAIL fill_fifo_count: got %0d, expected %0d", fifo_count, DEPTH); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b, expected 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b1 || {out_y, out_sel} !== exp_q[0])
      $display("FAIL fill_result_reg: got %b/%h, expected 1/%h", out_valid, {out_y, out_sel}, exp_q[0]);
    else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_sel} !== acc_q[1])
      $display("FAIL fill_issue_reg: got %h, expected %h", {alu_a, alu_b, alu_sel}, acc_q[1]);
    else n_pass++;

    s_out = {out_y, out_sel};
    s_iss = {alu_a, alu_b, alu_sel};
    s_cnt = fifo_count;
    for (int unsigned i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if ({out_y, out_sel} !== s_out || {alu_a, alu_b, alu_sel} !== s_iss || fifo_count !== s_cnt || out_valid !== 1'b1)
        $display("FAIL stall_hold[%0d]: got %h/%h/%0d, expected %h/%h/%0d", i, {out_y, out_sel}, {alu_a, alu_b, alu_sel}, fifo_count, s_out, s_iss, s_cnt);
      else n_pass++;
    end

    out_ready = 1'b1;
    gaps = 0;
    for (int unsigned i = 0; i < DEPTH + 2; i++) begin
      if (out_valid !== 1'b1) gaps++;
      cycle();
    end
    n_checks++; if (gaps !== 0) $display("FAIL drain_gaps: got %0d, expected 0", gaps); else n_pass++;
    n_checks++; if (fifo_count !== 0 || out_valid !== 1'b0) $display("FAIL drain_empty: got count %0d valid %b, expected 0/0", fifo_count, out_valid); else n_pass++;
    n_checks++; if (got_q.size() !== DEPTH + 2 || queue_mismatches() !== 0)
      $display("FAIL drain_order: got %0d results with %0d mismatches, expected %0d with 0", got_q.size(), queue_mismatches(), DEPTH + 2);
    else n_pass++;
    clear_model();
  endtask

  task automatic test_reset_mid();
    int stale;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      rand_cmd();
      cycle();
    end
    n_checks++; if (out_valid !== 1'b1 || fifo_count !== 3) $display("FAIL mid_setup: got valid %b count %0d, expected 1/3", out_valid, fifo_count); else n_pass++;
    rst = 1'b1; out_ready = 1'b1; rand_cmd();
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    clear_model();
    op_model = '0;
    n_checks++; if (fifo_count !== 0 || out_valid !== 1'b0) $display("FAIL mid_state: got count %0d valid %b, expected 0/0", fifo_count, out_valid); else n_pass++;
    n_checks++; if ({alu_a, alu_b, alu_sel, out_y, out_sel} !== 55'h0) $display("FAIL mid_regs: got %h, expected 0", {alu_a, alu_b, alu_sel, out_y, out_sel}); else n_pass++;
    n_checks++; if (op_count !== 16'h0 || in_ready !== 1'b1) $display("FAIL mid_counters: got op %h ready %b, expected 0/1", op_count, in_ready); else n_pass++;
    stale = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) stale++;
      cycle();
    end
    n_checks++; if (stale !== 0 || got_q.size() !== 0) $display("FAIL mid_stale: got %0d stale cycles, expected 0", stale); else n_pass++;
  endtask

  task automatic test_random();
    int inv_bad;
    int stall_bad;
    logic was_stalled;
    logic [19:0] s_out;
    inv_bad = 0; stall_bad = 0;
    for (int unsigned i = 0; i < 1000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 55);
      rand_cmd();
      if (in_ready !== (fifo_count != DEPTH) || fifo_count > DEPTH || exp_q.size() - got_q.size() > DEPTH + 2) inv_bad++;
      was_stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
      s_out = {out_y, out_sel};
      cycle();
      if (was_stalled && (out_valid !== 1'b1 || {out_y, out_sel} !== s_out)) stall_bad++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int unsigned i = 0; i < 50 && got_q.size() < exp_q.size(); i++) cycle();
    n_checks++; if (inv_bad !== 0) $display("FAIL rand_invariants: got %0d violations, expected 0", inv_bad); else n_pass++;
    n_checks++; if (stall_bad !== 0) $display("FAIL rand_stall: got %0d unstable stalls, expected 0", stall_bad); else n_pass++;
    n_checks++; if (got_q.size() !== exp_q.size() || queue_mismatches() !== 0)
      $display("FAIL rand_scoreboard: got %0d results with %0d mismatches, expected %0d with 0", got_q.size(), queue_mismatches(), exp_q.size());
    else n_pass++;
    n_checks++; if (op_count !== op_model) $display("FAIL rand_op_count: got %0d, expected %0d", op_count, op_model); else n_pass++;
    n_checks++; if (fifo_count !== 0) $display("FAIL rand_fifo_empty: got %0d, expected 0", fifo_count); else n_pass++;
    clear_model();
  endtask

  task automatic test_op_wrap();
    int cycles;
    int needed;
    needed = 65535 - int'(op_model);
    cycles = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (op_model != 16'hFFFF && cycles < 70000) begin
      rand_cmd();
      cycle();
      cycles++;
    end
    n_checks++; if (op_model !== 16'hFFFF || op_count !== 16'hFFFF) $display("FAIL wrap_preload: got %h, expected ffff", op_count); else n_pass++;
    n_checks++; if (cycles > needed + 3) $display("FAIL wrap_throughput: got %0d cycles, expected at most %0d", cycles, needed + 3); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL wrap_valid: got %b, expected 1", out_valid); else n_pass++;
    in_valid = 1'b0;
    cycle();
    n_checks++; if (op_count !== 16'h0000) $display("FAIL wrap_op_count: got %h, expected 0000", op_count); else n_pass++;
    for (int unsigned i = 0; i < 20 && got_q.size() < exp_q.size(); i++) cycle();
    n_checks++; if (got_q.size() !== exp_q.size() || queue_mismatches() !== 0)
      $display("FAIL wrap_scoreboard: got %0d results with %0d mismatches, expected %0d with 0", got_q.size(), queue_mismatches(), exp_q.size());
    else n_pass++;
    clear_model();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    op_model = '0;
    test_reset();
    test_single_op();
    test_fill_drain();
    test_reset_mid();
    test_random();
    test_op_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
